// File: rtl/frame_buffer_2w.sv
// Two-write-port pixel frame buffer with reset-time clear, port-2 collision FIFO and registered read.
// Optional FB_DEDUP_EN: a request identical to the same port's previous-cycle request is ignored.
module frame_buffer_2w #(
  parameter int unsigned   AW         = 15,
  parameter int unsigned   DW         = 3,
  parameter int unsigned   NPIX       = 20480,
  parameter logic [DW-1:0] INIT_COLOR = DW'(1),
  parameter int unsigned   FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] data1_i,
  input  logic          wr2_i,
  input  logic [AW-1:0] addr2_i,
  input  logic [DW-1:0] data2_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  output logic          init_busy_o,
  output logic          ovf_o
);

  localparam int unsigned   PW     = $clog2(FIFO_DEPTH);
  localparam int unsigned   CW     = PW + 1;
  localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
  localparam logic [AW-1:0] LAST_A = AW'(NPIX - 1);

  logic [DW-1:0] ram_q [NPIX];
  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];

  logic [PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [AW-1:0] clr_cnt_q, clr_cnt_d;
  logic          init_busy_q, init_busy_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic          req1, req2, v1, v2, empty, pop, push_req, room, push, drop;
  logic          we;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;

`ifdef FB_DEDUP_EN
  logic          p1_wr_q, p2_wr_q;
  logic [AW-1:0] p1_addr_q, p2_addr_q;
  logic [DW-1:0] p1_data_q, p2_data_q;

  // Previous-cycle request of each port, used to suppress repeats of a held request
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_wr_q   <= 1'b0;
      p1_addr_q <= '0;
      p1_data_q <= '0;
      p2_wr_q   <= 1'b0;
      p2_addr_q <= '0;
      p2_data_q <= '0;
    end else begin
      p1_wr_q   <= wr1_i;
      p1_addr_q <= addr1_i;
      p1_data_q <= data1_i;
      p2_wr_q   <= wr2_i;
      p2_addr_q <= addr2_i;
      p2_data_q <= data2_i;
    end
  end

  assign req1 = wr1_i && !(p1_wr_q && (p1_addr_q == addr1_i) && (p1_data_q == data1_i));
  assign req2 = wr2_i && !(p2_wr_q && (p2_addr_q == addr2_i) && (p2_data_q == data2_i));
`else
  assign req1 = wr1_i;
  assign req2 = wr2_i;
`endif

  // Requests are only live after the clear and only for on-screen addresses
  assign v1       = !init_busy_q && req1 && (addr1_i < NPIX_A);
  assign v2       = !init_busy_q && req2 && (addr2_i < NPIX_A);
  assign empty    = (fcnt_q == '0);
  assign pop      = !init_busy_q && !v1 && !empty;
  assign push_req = v2 && (v1 || !empty);
  assign room     = (fcnt_q - CW'(pop)) < CW'(FIFO_DEPTH);
  assign push     = push_req && room;
  assign drop     = push_req && !room;

  always_comb begin
    we          = 1'b0;
    wa          = '0;
    wd          = '0;
    clr_cnt_d   = clr_cnt_q;
    init_busy_d = init_busy_q;
    rptr_d      = rptr_q + PW'(pop);
    wptr_d      = wptr_q + PW'(push);
    fcnt_d      = fcnt_q + CW'(push) - CW'(pop);
    ovf_d       = ovf_q | drop;
    rd_data_d   = (rd_addr_i < NPIX_A) ? ram_q[rd_addr_i] : '0;
    if (init_busy_q) begin
      we        = 1'b1;
      wa        = clr_cnt_q;
      wd        = INIT_COLOR;
      clr_cnt_d = clr_cnt_q + AW'(1);
      if (clr_cnt_q == LAST_A) init_busy_d = 1'b0;
    end else if (v1) begin
      we = 1'b1;
      wa = addr1_i;
      wd = data1_i;
    end else if (!empty) begin
      we = 1'b1;
      wa = fifo_addr_q[rptr_q];
      wd = fifo_data_q[rptr_q];
    end else if (v2) begin
      we = 1'b1;
      wa = addr2_i;
      wd = data2_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_cnt_q   <= '0;
      init_busy_q <= 1'b1;
      rptr_q      <= '0;
      wptr_q      <= '0;
      fcnt_q      <= '0;
      ovf_q       <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      clr_cnt_q   <= clr_cnt_d;
      init_busy_q <= init_busy_d;
      rptr_q      <= rptr_d;
      wptr_q      <= wptr_d;
      fcnt_q      <= fcnt_d;
      ovf_q       <= ovf_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Storage arrays carry no reset; the clear sequence initialises the frame
  always_ff @(posedge clk) begin
    if (we) ram_q[wa] <= wd;
    if (push) begin
      fifo_addr_q[wptr_q] <= addr2_i;
      fifo_data_q[wptr_q] <= data2_i;
    end
  end

  assign rd_data_o   = rd_data_q;
  assign init_busy_o = init_busy_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_frame_buffer_2w.sv
// Directed self-checking bench for frame_buffer_2w; expectations follow FB_DEDUP_EN when defined.
module tb_frame_buffer_2w;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr1, wr2;
  logic [14:0] addr1, addr2, rd_addr;
  logic [2:0]  data1, data2;
  logic [2:0]  rd_data;
  logic        init_busy, ovf;

  int checks = 0;
  int errors = 0;
  int n;

  frame_buffer_2w dut (
    .clk         (clk),
    .rst         (rst),
    .wr1_i       (wr1),
    .addr1_i     (addr1),
    .data1_i     (data1),
    .wr2_i       (wr2),
    .addr2_i     (addr2),
    .data2_i     (data2),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .init_busy_o (init_busy),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rd(input logic [14:0] a, input logic [2:0] e, input string tag);
    rd_addr = a;
    tick();
    check(tag, 32'(rd_data), 32'(e));
  endtask

  task automatic idle(input int cycles);
    wr1 = 1'b0;
    wr2 = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
  endtask

  // Runs the clear to completion; optionally drives stray writes to already-cleared pixels
  task automatic run_clear(input logic inject, output int cnt);
    cnt   = 0;
    addr1 = 15'd2;
    data1 = 3'b111;
    addr2 = 15'd3;
    data2 = 3'b110;
    while (init_busy && cnt < 30000) begin
      wr1 = inject && (cnt == 10);
      wr2 = inject && (cnt == 10);
      tick();
      cnt++;
    end
    wr1 = 1'b0;
    wr2 = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr1 = 1'b0; wr2 = 1'b0;
    addr1 = '0; addr2 = '0; data1 = '0; data2 = '0; rd_addr = '0;
    tick();
    check("rst_busy", 32'(init_busy), 32'd1);
    check("rst_rdata", 32'(rd_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;

    // 1: clear duration and contents
    run_clear(1'b0, n);
    check("clear_cycles", 32'(n), 32'd20480);
    rd(15'd0, 3'b001, "clr_0");
    rd(15'd10320, 3'b001, "clr_10320");
    rd(15'd20479, 3'b001, "clr_20479");
    check("clr_ovf", 32'(ovf), 32'd0);

    // 2: single port-1 write
    wr1 = 1'b1; addr1 = 15'd15440; data1 = 3'b010;
    tick();
    wr1 = 1'b0;
    rd(15'd15440, 3'b010, "p1_write");

    // 3: collision, queued entry drains next cycle (read during that write sees old data)
    wr1 = 1'b1; addr1 = 15'd100; data1 = 3'b010;
    wr2 = 1'b1; addr2 = 15'd200; data2 = 3'b111;
    tick();
    wr1 = 1'b0; wr2 = 1'b0;
    rd(15'd200, 3'b001, "drain_old");
    rd(15'd200, 3'b111, "drain_new");
    rd(15'd100, 3'b010, "coll_p1");

    // Off-screen port-2 writes never queue or overflow; last valid pixel is writable
    for (int i = 0; i < 6; i++) begin
      wr1 = 1'b1; addr1 = 15'(50 + i); data1 = 3'b011;
      wr2 = 1'b1; addr2 = 15'(20480 + i); data2 = 3'b111;
      tick();
    end
    idle(2);
    check("oor_ovf", 32'(ovf), 32'd0);
    rd(15'd55, 3'b011, "oor_p1");
    wr2 = 1'b1; addr2 = 15'd20479; data2 = 3'b110;
    tick();
    wr2 = 1'b0;
    rd(15'd20479, 3'b110, "last_pix");

    // 4: FIFO overflow on the fifth queued entry
    for (int i = 0; i < 5; i++) begin
      wr1 = 1'b1; addr1 = 15'(40 + i); data1 = 3'b010;
      wr2 = 1'b1; addr2 = 15'(300 + i); data2 = 3'b100;
      tick();
      check($sformatf("ovf_step%0d", i), 32'(ovf), (i == 4) ? 32'd1 : 32'd0);
    end
    idle(6);
    for (int i = 0; i < 4; i++) rd(15'(300 + i), 3'b100, $sformatf("fifo_%0d", 300 + i));
    rd(15'd304, 3'b001, "dropped_304");
    rd(15'd44, 3'b010, "held_p1_44");

    // 5: same address on both ports, port 2 wins
    wr1 = 1'b1; addr1 = 15'd10320; data1 = 3'b010;
    wr2 = 1'b1; addr2 = 15'd10320; data2 = 3'b100;
    tick();
    idle(1);
    rd(15'd10320, 3'b100, "same_addr");

    // Reset mid-clear restarts the count; writes during the clear are ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(100);
    check("mid_busy", 32'(init_busy), 32'd1);
    rst = 1'b1;
    tick();
    check("rst2_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    run_clear(1'b1, n);
    check("restart_cycles", 32'(n), 32'd20480);
    idle(8);
    rd(15'd2, 3'b001, "ign_p1");
    rd(15'd3, 3'b001, "ign_p2");
    rd(15'd304, 3'b001, "reclr_304");
    check("post_ovf", 32'(ovf), 32'd0);

    // 6: held port-2 request against busy port 1
    for (int i = 0; i < 10; i++) begin
      wr1 = 1'b1; addr1 = 15'(600 + i); data1 = 3'b010;
      wr2 = 1'b1; addr2 = 15'd500; data2 = 3'b111;
      tick();
    end
    idle(6);
`ifdef FB_DEDUP_EN
    check("held_ovf", 32'(ovf), 32'd0);
`else
    check("held_ovf", 32'(ovf), 32'd1);
`endif
    rd(15'd500, 3'b111, "held_500");
    rd(15'd609, 3'b010, "held_p1_609");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
